ddr_refresh_timer: RTL and testbench
====================================

DDR_REFRESH_TIMER -- requirements
Module: ddr_refresh_timer

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 Parameter TREFI_NS, default 7800, average refresh interval in ns.
REQ-003 Parameter MAX_PENDING, default 8, refresh credits held before loss; legal range 1..15.
REQ-004 Parameter URGENT_LEVEL, default 6, pending count at which refresh becomes urgent; legal range 1..MAX_PENDING.
REQ-005 Port: clk, input, 1, sole clock, rising edge.
REQ-006 Port: reset, input, 1, asynchronous active-high reset.
REQ-007 Port: enable, input, 1, interval timer runs when high.
REQ-008 Port: refresh_ack, input, 1, single-cycle pulse from the controller per completed refresh.
REQ-009 Port: tick, output, 1, one-cycle pulse per elapsed interval.
REQ-010 Port: refresh_req, output, 1, at least one refresh owed.
REQ-011 Port: refresh_urgent, output, 1, pending count at or above URGENT_LEVEL.
REQ-012 Port: pending, output, 4, refresh credits currently owed.

Function
REQ-013 PERIOD SHALL be the elaboration-time integer (CLK_FREQ/1000)*TREFI_NS/1000000 (390 at defaults); PERIOD < 2 SHALL be an elaboration error.
REQ-014 The down-counter SHALL be sized to hold PERIOD-1, load PERIOD-1, and decrement each cycle while enable is high.
REQ-015 When the counter is 0 with enable high, tick SHALL be 1 on the next cycle and the counter SHALL reload PERIOD-1, giving exactly one tick every PERIOD cycles.
REQ-016 While enable is low the counter SHALL be held at PERIOD-1 and tick SHALL be 0; pending SHALL still respond to refresh_ack.
REQ-017 pending SHALL increment one cycle after tick is internally generated (the same edge tick rises), and decrement on an edge where refresh_ack is high and pending > 0.
REQ-018 A tick and an accepted ack on the same edge SHALL leave pending unchanged.
REQ-019 A tick with pending == MAX_PENDING and no ack SHALL leave pending at MAX_PENDING and count as a dropped refresh.
REQ-020 refresh_ack with pending == 0 SHALL be ignored.
REQ-021 State SHALL follow pending: IDLE (0), POSTPONE (1..URGENT_LEVEL-1), URGENT (>= URGENT_LEVEL); transitions occur only through REQ-017..REQ-019.
REQ-022 refresh_req and refresh_urgent SHALL be registered and reflect the state in the same cycle as the updated pending value.
REQ-023 All outputs SHALL be driven from flops; there SHALL be no combinational path from input to output.

Reset
REQ-024 Asserting reset SHALL immediately force counter = PERIOD-1, pending = 0, tick = 0, refresh_req = 0, refresh_urgent = 0, and state IDLE.
REQ-025 Reset asserted mid-interval or mid-backlog SHALL discard all owed credits; the first tick after release SHALL occur PERIOD cycles after the first edge with enable high.

Configuration
REQ-026 With macro DDR_REFRESH_STATS_EN defined, the block SHALL add output port drop_count (8 bits), incremented on each dropped refresh (REQ-019), saturating at 255, and cleared only by reset.
REQ-027 Without DDR_REFRESH_STATS_EN, the drop_count port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-028 Defaults, enable=1, no ack for 2000 cycles -> tick every 390 cycles; first tick 390 cycles after enable; pending = 5; refresh_req = 1; refresh_urgent = 0.
REQ-029 Defaults, no ack for 6 intervals -> refresh_urgent rises with pending = 6; one ack -> pending = 5 and refresh_urgent = 0 on the next cycle.
REQ-030 Defaults, no ack for 10 intervals, with DDR_REFRESH_STATS_EN -> pending saturates at 8 and drop_count = 2.
REQ-031 pending = 3, ack on the same edge as tick -> pending stays 3; ack with pending = 0 -> pending stays 0.
REQ-032 enable dropped for 500 cycles mid-interval -> no tick; counter restarts at 389 and the next tick comes 390 cycles after enable returns.
REQ-033 reset pulsed asynchronously between edges with pending = 4 -> all outputs 0 before the next edge; after release, behaviour matches REQ-028.

Source files
------------

// File: rtl/ddr_refresh_timer.sv
// ddr_refresh_timer
// Generates one tick per average refresh interval (tREFI) and keeps a
// saturating count of refresh credits owed to the DRAM. The controller
// retires credits with refresh_ack. refresh_req and refresh_urgent follow a
// small IDLE/POSTPONE/URGENT state machine driven by the pending count.
//
// Handshake: refresh_ack is a single-cycle pulse, sampled on the rising edge,
// and retires one credit only when pending is non-zero. A tick and an
// accepted ack on the same edge cancel each other out.
//
// Optional feature: define DDR_REFRESH_STATS_EN to add the 8-bit drop_count
// output. It counts refreshes lost because the backlog was already full,
// saturates at 255, and is cleared only by reset.
//
// Every output comes straight from a flop.

module ddr_refresh_timer #(
    parameter int CLK_FREQ     = 50000000,
    parameter int TREFI_NS     = 7800,
    parameter int MAX_PENDING  = 8,
    parameter int URGENT_LEVEL = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       refresh_ack,
    output logic       tick,
    output logic       refresh_req,
    output logic       refresh_urgent,
    output logic [3:0] pending
`ifdef DDR_REFRESH_STATS_EN
    ,
    output logic [7:0] drop_count
`endif
);

    // Interval length in clock cycles. Scale in 64 bits so large
    // frequencies cannot overflow.
    localparam longint PERIOD_L = (longint'(CLK_FREQ) / 1000) * longint'(TREFI_NS) / 1000000;
    localparam int     PERIOD   = int'(PERIOD_L);
    localparam int     CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [3:0]       MAX_P      = 4'(MAX_PENDING);
    localparam logic [3:0]       URG_P      = 4'(URGENT_LEVEL);

    // Reject configurations the timer cannot honour.
    if (PERIOD < 2) begin : g_bad_period
        $error("ddr_refresh_timer: PERIOD must be at least 2 cycles");
    end
    if (MAX_PENDING < 1 || MAX_PENDING > 15) begin : g_bad_max
        $error("ddr_refresh_timer: MAX_PENDING must be in 1..15");
    end
    if (URGENT_LEVEL < 1 || URGENT_LEVEL > MAX_PENDING) begin : g_bad_urgent
        $error("ddr_refresh_timer: URGENT_LEVEL must be in 1..MAX_PENDING");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_POSTPONE = 2'd1,
        ST_URGENT   = 2'd2
    } state_t;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [3:0]       r_pending;
    logic             r_req;
    logic             r_urgent;
    state_t           r_state;

    logic             w_tick_gen;
    logic             w_ack_ok;
    logic             w_inc;
    logic             w_dec;
    logic             w_drop;
    logic [3:0]       w_pending_nxt;
    state_t           w_state_nxt;

    // An interval ends when the counter sits at zero while enabled.
    assign w_tick_gen = enable && (r_cnt == CNT_ZERO);

    // An ack only counts when there is something to retire.
    assign w_ack_ok = refresh_ack && (r_pending != 4'd0);

    // Credit bookkeeping: a tick and an accepted ack cancel each other out;
    // a tick on a full backlog is lost.
    always_comb begin
        w_inc  = 1'b0;
        w_dec  = 1'b0;
        w_drop = 1'b0;
        if (w_tick_gen && !w_ack_ok) begin
            if (r_pending == MAX_P) begin
                w_drop = 1'b1;
            end else begin
                w_inc = 1'b1;
            end
        end else if (!w_tick_gen && w_ack_ok) begin
            w_dec = 1'b1;
        end
    end

    // Next pending value from the increment/decrement decision.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_inc) begin
            w_pending_nxt = r_pending + 4'd1;
        end else if (w_dec) begin
            w_pending_nxt = r_pending - 4'd1;
        end
    end

    // State moves only when pending actually changes, landing on the band
    // that the new pending value falls into.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_inc) begin
                    w_state_nxt = (w_pending_nxt >= URG_P) ? ST_URGENT : ST_POSTPONE;
                end
            end
            ST_POSTPONE: begin
                if (w_inc && (w_pending_nxt >= URG_P)) begin
                    w_state_nxt = ST_URGENT;
                end else if (w_dec && (w_pending_nxt == 4'd0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_URGENT: begin
                if (w_dec && (w_pending_nxt < URG_P)) begin
                    w_state_nxt = (w_pending_nxt == 4'd0) ? ST_IDLE : ST_POSTPONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Interval down-counter and registered tick; held at reload while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= CNT_RELOAD;
            r_tick <= 1'b0;
        end else if (!enable) begin
            r_cnt  <= CNT_RELOAD;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_ZERO) begin
            r_cnt  <= CNT_RELOAD;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_tick <= 1'b0;
        end
    end

    // Refresh state machine: pending, state and the request flags update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= 4'd0;
            r_req     <= 1'b0;
            r_urgent  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_req     <= (w_state_nxt != ST_IDLE);
            r_urgent  <= (w_state_nxt == ST_URGENT);
        end
    end

`ifdef DDR_REFRESH_STATS_EN
    logic [7:0] r_drop_count;

    // Saturating count of refreshes lost to a full backlog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= 8'd0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
`endif

    assign tick           = r_tick;
    assign refresh_req    = r_req;
    assign refresh_urgent = r_urgent;
    assign pending        = r_pending;

endmodule

// File: tb/tb_ddr_refresh_timer.sv
// Directed bench for ddr_refresh_timer at default parameters
// (PERIOD = 390 cycles, MAX_PENDING = 8, URGENT_LEVEL = 6).

module tb_ddr_refresh_timer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       refresh_ack;
    logic       tick;
    logic       refresh_req;
    logic       refresh_urgent;
    logic [3:0] pending;
`ifdef DDR_REFRESH_STATS_EN
    logic [7:0] drop_count;
`endif

    int total = 0;
    int bad   = 0;

    ddr_refresh_timer dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .refresh_ack    (refresh_ack),
        .tick           (tick),
        .refresh_req    (refresh_req),
        .refresh_urgent (refresh_urgent),
        .pending        (pending)
`ifdef DDR_REFRESH_STATS_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges until tick is seen high; gives up after 1000 edges.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (tick !== 1'b1 && n < 1000);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int n;
    int tick_seen;

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        refresh_ack = 1'b0;
        step(3);

        // Reset state.
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        check("rst_req", {31'd0, refresh_req}, 32'd0);
        check("rst_urgent", {31'd0, refresh_urgent}, 32'd0);
`ifdef DDR_REFRESH_STATS_EN
        check("rst_drop", {24'd0, drop_count}, 32'd0);
`endif

        // Release reset and enable: first tick 390 edges later.
        reset  = 1'b0;
        enable = 1'b1;
        wait_tick(n);
        check("first_tick_latency", n, 32'd390);
        check("pend_after_1", {28'd0, pending}, 32'd1);
        check("req_after_1", {31'd0, refresh_req}, 32'd1);
        check("urg_after_1", {31'd0, refresh_urgent}, 32'd0);
        wait_tick(n);
        check("tick_period", n, 32'd390);
        step(1);
        check("tick_one_cycle", {31'd0, tick}, 32'd0);

        // Edge 781 now; run to edge 2000 (ticks at 1170, 1560, 1950).
        step(1219);
        check("pend_2000", {28'd0, pending}, 32'd5);
        check("req_2000", {31'd0, refresh_req}, 32'd1);
        check("urg_2000", {31'd0, refresh_urgent}, 32'd0);

        // Sixth interval makes it urgent.
        wait_tick(n);
        check("tick_6_latency", n, 32'd340);
        check("pend_6", {28'd0, pending}, 32'd6);
        check("urg_6", {31'd0, refresh_urgent}, 32'd1);

        // One ack drops back below the urgent level.
        refresh_ack = 1'b1;
        step(1);
        refresh_ack = 1'b0;
        check("pend_ack_5", {28'd0, pending}, 32'd5);
        check("urg_ack_5", {31'd0, refresh_urgent}, 32'd0);
        check("req_ack_5", {31'd0, refresh_req}, 32'd1);

        // Fill to the cap, then two more ticks are lost.
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        check("pend_full", {28'd0, pending}, 32'd8);
        check("urg_full", {31'd0, refresh_urgent}, 32'd1);
        wait_tick(n);
        check("pend_sat_1", {28'd0, pending}, 32'd8);
`ifdef DDR_REFRESH_STATS_EN
        check("drop_1", {24'd0, drop_count}, 32'd1);
`endif
        wait_tick(n);
        check("pend_sat_2", {28'd0, pending}, 32'd8);
`ifdef DDR_REFRESH_STATS_EN
        check("drop_2", {24'd0, drop_count}, 32'd2);
`endif

        // Five back-to-back acks: 8 -> 3 (edges T+1..T+5).
        refresh_ack = 1'b1;
        step(5);
        refresh_ack = 1'b0;
        check("pend_3", {28'd0, pending}, 32'd3);
        check("urg_3", {31'd0, refresh_urgent}, 32'd0);

        // Ack on the tick edge (T+390) leaves pending unchanged.
        step(384);
        refresh_ack = 1'b1;
        step(1);
        refresh_ack = 1'b0;
        check("tick_with_ack", {31'd0, tick}, 32'd1);
        check("pend_tick_ack", {28'd0, pending}, 32'd3);

        // Drain to zero, then an extra ack is ignored.
        refresh_ack = 1'b1;
        step(3);
        check("pend_drained", {28'd0, pending}, 32'd0);
        check("req_drained", {31'd0, refresh_req}, 32'd0);
        step(1);
        refresh_ack = 1'b0;
        check("pend_ack_at_0", {28'd0, pending}, 32'd0);
        check("req_ack_at_0", {31'd0, refresh_req}, 32'd0);

        // Disable mid-interval for 500 cycles: no tick at all.
        enable    = 1'b0;
        tick_seen = 0;
        for (int i = 0; i < 500; i++) begin
            step(1);
            if (tick === 1'b1) tick_seen++;
        end
        check("no_tick_disabled", tick_seen, 32'd0);
        check("pend_disabled", {28'd0, pending}, 32'd0);

        // Re-enable: full interval before the next tick.
        enable = 1'b1;
        wait_tick(n);
        check("tick_after_enable", n, 32'd390);
        check("pend_after_enable", {28'd0, pending}, 32'd1);

        // Build a backlog of 4, then reset between edges right after a tick.
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        check("pend_4", {28'd0, pending}, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("async_tick", {31'd0, tick}, 32'd0);
        check("async_pending", {28'd0, pending}, 32'd0);
        check("async_req", {31'd0, refresh_req}, 32'd0);
        check("async_urgent", {31'd0, refresh_urgent}, 32'd0);
        step(2);
        reset = 1'b0;

        // After release, timing restarts from scratch.
        wait_tick(n);
        check("tick_after_reset", n, 32'd390);
        check("pend_after_reset", {28'd0, pending}, 32'd1);
        check("req_after_reset", {31'd0, refresh_req}, 32'd1);
`ifdef DDR_REFRESH_STATS_EN
        check("drop_after_reset", {24'd0, drop_count}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
